// File: rtl/mul_add_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_add_pipe_pkg
//  Purpose  : Shared mode encodings and width helper for the multiply-add unit.
//  Revision : 1.0  initial release
// ============================================================================
package mul_add_pipe_pkg;

    localparam logic MODE_MULADD = 1'b0;
    localparam logic MODE_ACC    = 1'b1;

    // Four guard bits above the full product width give headroom for
    // sixteen worst-case accumulations before saturation.
    function automatic int default_acc_w(input int w);
        return 2 * w + 4;
    endfunction

endpackage : mul_add_pipe_pkg
`default_nettype wire

// File: rtl/mul_add_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_add_pipe_if
//  Purpose  : Operand/result handshake bundle for mul_add_pipe.
//  Revision : 1.0  initial release
// ============================================================================
interface mul_add_pipe_if
    import mul_add_pipe_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = default_acc_w(W)
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     c;
    logic             mode;
    logic             clr_acc;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c, mode, clr_acc, out_ready,
        input  in_ready, out_valid, out, ovf
    );

    modport slave (
        input  in_valid, a, b, c, mode, clr_acc, out_ready,
        output in_ready, out_valid, out, ovf
    );

endinterface : mul_add_pipe_if
`default_nettype wire

// File: rtl/mul_add_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage
//  Purpose  : Enable-gated pipeline register carrying {valid, mode, data}.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_valid,
    input  logic          i_mode,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic          o_mode,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic          r_mode;
    logic [DW-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_mode  <= 1'b0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_mode  <= i_mode;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_data  = r_data;

endmodule : pipe_stage
`default_nettype wire

// File: rtl/mul_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mul_add_pipe
//  Purpose  : Pipelined unsigned a*b+c with valid/ready flow control and a
//             saturating accumulate mode.
//  Revision : 1.0  initial release
// ============================================================================
module mul_add_pipe
    import mul_add_pipe_pkg::*;
#(
    parameter int W      = 8,
    parameter int STAGES = 3,
    parameter int ACC_W  = default_acc_w(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    mul_add_pipe_if.slave bus
);

    localparam int SW  = 2 * W;
    localparam int AW1 = ACC_W + 1;

    if ((STAGES < 1) || (STAGES > 4)) begin : g_bad_stages
        $error("mul_add_pipe: STAGES must be in 1..4");
    end

    if (ACC_W < (2 * W + 1)) begin : g_bad_acc_w
        $error("mul_add_pipe: ACC_W must be at least 2*W+1");
    end

    logic             w_stall;
    logic             w_en;
    logic             w_fin_valid;
    logic             w_fin_mode;
    logic [SW-1:0]    w_fin_sum;

    logic             r_out_valid;
    logic [ACC_W-1:0] r_out;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    // A single global stall: nothing moves while a result waits on the consumer.
    assign w_stall      = r_out_valid && !bus.out_ready;
    assign w_en         = !w_stall;
    assign bus.in_ready = w_en;

    if (STAGES == 1) begin : g_comb
        assign w_fin_valid = bus.in_valid;
        assign w_fin_mode  = bus.mode;
        assign w_fin_sum   = SW'(bus.a) * SW'(bus.b) + SW'(bus.c);
    end else begin : g_piped
        logic              w_s1_valid;
        logic              w_s1_mode;
        logic [3*W-1:0]    w_s1_ops;
        logic [W-1:0]      w_a1;
        logic [W-1:0]      w_b1;
        logic [W-1:0]      w_c1;
        logic [STAGES-2:0] w_v;
        logic [STAGES-2:0] w_m;
        logic [SW-1:0]     w_s [STAGES-1];

        pipe_stage #(
            .DW (3 * W)
        ) u_stage1 (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_en),
            .i_valid (bus.in_valid),
            .i_mode  (bus.mode),
            .i_data  ({bus.a, bus.b, bus.c}),
            .o_valid (w_s1_valid),
            .o_mode  (w_s1_mode),
            .o_data  (w_s1_ops)
        );

        assign {w_a1, w_b1, w_c1} = w_s1_ops;

        // The arithmetic sits right after the operand register; later stages
        // only delay the finished sum.
        assign w_v[0] = w_s1_valid;
        assign w_m[0] = w_s1_mode;
        assign w_s[0] = SW'(w_a1) * SW'(w_b1) + SW'(w_c1);

        for (genvar k = 1; k < STAGES - 1; k++) begin : g_delay
            pipe_stage #(
                .DW (SW)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_en    (w_en),
                .i_valid (w_v[k-1]),
                .i_mode  (w_m[k-1]),
                .i_data  (w_s[k-1]),
                .o_valid (w_v[k]),
                .o_mode  (w_m[k]),
                .o_data  (w_s[k])
            );
        end

        assign w_fin_valid = w_v[STAGES-2];
        assign w_fin_mode  = w_m[STAGES-2];
        assign w_fin_sum   = w_s[STAGES-2];
    end

    logic [ACC_W-1:0] w_acc_base;
    logic [AW1-1:0]   w_acc_sum;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_acc_op;

    // A clear on the same edge as an accumulate is applied before the add.
    assign w_acc_base = bus.clr_acc ? '0 : r_acc;
    assign w_acc_sum  = {1'b0, w_acc_base} + AW1'(w_fin_sum);
    assign w_acc_next = w_acc_sum[ACC_W] ? '1 : w_acc_sum[ACC_W-1:0];
    assign w_acc_op   = w_en && w_fin_valid && (w_fin_mode == MODE_ACC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_acc_op) begin
            r_acc <= w_acc_next;
            r_ovf <= (r_ovf && !bus.clr_acc) || w_acc_sum[ACC_W];
        end else if (bus.clr_acc) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_en) begin
            r_out_valid <= w_fin_valid;
            if (w_fin_valid) begin
                r_out <= (w_fin_mode == MODE_ACC) ? w_acc_next : ACC_W'(w_fin_sum);
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.ovf       = r_ovf;

endmodule : mul_add_pipe
`default_nettype wire

// File: tb/tb_mul_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_add_pipe
//  Purpose  : Self-checking bench for mul_add_pipe against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_add_pipe;
    import mul_add_pipe_pkg::*;

    localparam int     W       = 8;
    localparam int     STAGES  = 3;
    localparam int     ACC_W   = 20;
    localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic         md;
    } op_t;

    typedef struct {
        longint val;
        logic   ovf;
        int     cyc;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mul_add_pipe_if #(.W(W), .ACC_W(ACC_W)) bus ();

    mul_add_pipe #(
        .W      (W),
        .STAGES (STAGES),
        .ACC_W  (ACC_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint m_acc  = 0;
    logic   m_ovf  = 1'b0;
    op_t    ops[$];
    res_t   got_q[$];
    res_t   exp_q[$];
    int     stall_cyc, stall_bad, hold_bad, rdy_low;

    function automatic void add_op(input int a, input int b, input int c, input logic md);
        op_t op;
        op.a = a[W-1:0];
        op.b = b[W-1:0];
        op.c = c[W-1:0];
        op.md = md;
        ops.push_back(op);
    endfunction

    // Reference: results in acceptance order, accumulator saturates at ACC_MAX.
    function automatic void model_accept(input op_t op);
        longint s;
        res_t   e;
        s = longint'(op.a) * longint'(op.b) + longint'(op.c);
        if (op.md == MODE_ACC) begin
            m_acc = m_acc + s;
            if (m_acc > ACC_MAX) begin
                m_acc = ACC_MAX;
                m_ovf = 1'b1;
            end
            e.val = m_acc;
        end else begin
            e.val = s;
        end
        e.ovf = m_ovf;
        e.cyc = 0;
        exp_q.push_back(e);
    endfunction

    task automatic run_ops(input int stall_at, input int stall_len, input int min_cyc);
        int   n;
        int   cyc;
        logic prev_stall;
        logic [ACC_W-1:0] prev_out;
        n = ops.size();
        got_q.delete();
        stall_cyc = 0; stall_bad = 0; hold_bad = 0; rdy_low = 0;
        cyc = 0; prev_stall = 1'b0; prev_out = '0;
        fork
            begin
                while (ops.size() > 0) begin
                    int  wait_n;
                    op_t op;
                    op = ops.pop_front();
                    @(negedge clk);
                    bus.in_valid = 1'b1;
                    bus.a = op.a; bus.b = op.b; bus.c = op.c; bus.mode = op.md;
                    #1;
                    wait_n = 0;
                    while (!bus.in_ready && wait_n < 100) begin
                        @(negedge clk);
                        #1;
                        wait_n++;
                    end
                    if (!bus.in_ready) begin
                        checks++; errors++;
                        $display("FAIL in_ready_timeout: in_ready=%0b, required 1 within 100 cycles", bus.in_ready);
                    end else begin
                        model_accept(op);
                    end
                end
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            begin
                while ((got_q.size() < n || cyc < min_cyc) && cyc < 500) begin
                    res_t r;
                    @(negedge clk);
                    bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
                    #2;
                    if (prev_stall && bus.out !== prev_out) hold_bad++;
                    if (bus.out_valid && !bus.out_ready) begin
                        stall_cyc++;
                        if (bus.in_ready) stall_bad++;
                    end else if (!bus.in_ready) begin
                        rdy_low++;
                    end
                    if (bus.out_valid && bus.out_ready) begin
                        r.val = longint'(bus.out);
                        r.ovf = bus.ovf;
                        r.cyc = cyc;
                        got_q.push_back(r);
                    end
                    prev_stall = bus.out_valid && !bus.out_ready;
                    prev_out   = bus.out;
                    cyc++;
                end
                bus.out_ready = 1'b1;
            end
        join
    endtask

    task automatic clear_acc();
        @(negedge clk);
        bus.clr_acc = 1'b1;
        @(negedge clk);
        bus.clr_acc = 1'b0;
        m_acc = 0;
        m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0; bus.mode = MODE_MULADD;
        bus.clr_acc = 1'b0; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, required 0", bus.out_valid); end
        if (bus.out !== '0) begin errors++; $display("FAIL reset_out: got %0d, required 0", bus.out); end
        if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b, required 0", bus.ovf); end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks += 2;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, required 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %0b, required 0", bus.out_valid); end
    endtask

    task automatic test_single_pulse();
        exp_q.delete();
        add_op(3, 4, 5, MODE_MULADD);
        run_ops(1000, 0, 12);
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL pulse_count: got %0d results, required 1", got_q.size()); end
        else begin
            checks += 3;
            if (got_q[0].val != 17) begin errors++; $display("FAIL pulse_value: got %0d, required 17", got_q[0].val); end
            if (got_q[0].cyc != STAGES) begin errors++; $display("FAIL pulse_latency: got %0d, required %0d", got_q[0].cyc, STAGES); end
            if (got_q[0].ovf !== 1'b0) begin errors++; $display("FAIL pulse_ovf: got %0b, required 0", got_q[0].ovf); end
        end
    endtask

    task automatic test_max_muladd();
        exp_q.delete();
        add_op(255, 255, 255, MODE_MULADD);
        run_ops(1000, 0, 6);
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL max_count: got %0d results, required 1", got_q.size()); end
        else begin
            checks += 2;
            if (got_q[0].val != 65280) begin errors++; $display("FAIL max_value: got %0d, required 65280", got_q[0].val); end
            if (got_q[0].ovf !== 1'b0) begin errors++; $display("FAIL max_ovf: got %0b, required 0", got_q[0].ovf); end
        end
    endtask

    task automatic test_stream();
        exp_q.delete();
        for (int i = 1; i <= 10; i++) add_op(i, i + 1, i, MODE_MULADD);
        run_ops(1000, 0, 0);
        checks += 2;
        if (got_q.size() != 10) begin errors++; $display("FAIL stream_count: got %0d, required 10", got_q.size()); end
        if (rdy_low != 0) begin errors++; $display("FAIL stream_in_ready: low for %0d cycles, required 0", rdy_low); end
        for (int i = 0; i < got_q.size() && i < 10; i++) begin
            checks += 2;
            if (got_q[i].val != longint'((i + 1) * (i + 2) + (i + 1))) begin
                errors++; $display("FAIL stream_value[%0d]: got %0d, required %0d", i, got_q[i].val, (i + 1) * (i + 2) + (i + 1));
            end
            if (got_q[i].cyc != got_q[0].cyc + i) begin
                errors++; $display("FAIL stream_consecutive[%0d]: cycle %0d, required %0d", i, got_q[i].cyc, got_q[0].cyc + i);
            end
        end
    endtask

    task automatic test_stall();
        longint total;
        exp_q.delete();
        for (int i = 1; i <= 10; i++) add_op(i, i + 1, i, MODE_MULADD);
        run_ops(5, 4, 0);
        total = 0;
        foreach (got_q[i]) total += got_q[i].val;
        checks += 5;
        if (got_q.size() != 10) begin errors++; $display("FAIL stall_count: got %0d, required 10", got_q.size()); end
        if (stall_cyc != 4) begin errors++; $display("FAIL stall_cycles: got %0d, required 4", stall_cyc); end
        if (stall_bad != 0) begin errors++; $display("FAIL stall_in_ready: high in %0d stalled cycles, required 0", stall_bad); end
        if (hold_bad != 0) begin errors++; $display("FAIL stall_hold: out changed %0d times, required 0", hold_bad); end
        if (total != 495) begin errors++; $display("FAIL stall_total: got %0d, required 495", total); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].val != exp_q[i].val) begin
                errors++; $display("FAIL stall_value[%0d]: got %0d, required %0d", i, got_q[i].val, exp_q[i].val);
            end
        end
    endtask

    task automatic test_accumulate();
        longint req [3];
        req[0] = 100; req[1] = 200; req[2] = 300;
        clear_acc();
        exp_q.delete();
        repeat (3) add_op(10, 10, 0, MODE_ACC);
        run_ops(1000, 0, 0);
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL acc_count: got %0d, required 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            checks++;
            if (got_q[i].val != req[i]) begin errors++; $display("FAIL acc_value[%0d]: got %0d, required %0d", i, got_q[i].val, req[i]); end
        end
    endtask

    task automatic test_saturation();
        clear_acc();
        exp_q.delete();
        repeat (17) add_op(255, 255, 255, MODE_ACC);
        add_op(1, 1, 0, MODE_ACC);
        run_ops(1000, 0, 0);
        checks++;
        if (got_q.size() != 18) begin errors++; $display("FAIL sat_count: got %0d, required 18", got_q.size()); end
        else begin
            checks += 4;
            if (got_q[15].val != 1044480 || got_q[15].ovf !== 1'b0) begin
                errors++; $display("FAIL sat_16th: got %0d ovf %0b, required 1044480 ovf 0", got_q[15].val, got_q[15].ovf);
            end
            if (got_q[16].val != 1048575 || got_q[16].ovf !== 1'b1) begin
                errors++; $display("FAIL sat_17th: got %0d ovf %0b, required 1048575 ovf 1", got_q[16].val, got_q[16].ovf);
            end
            if (got_q[17].val != 1048575 || got_q[17].ovf !== 1'b1) begin
                errors++; $display("FAIL sat_hold: got %0d ovf %0b, required 1048575 ovf 1", got_q[17].val, got_q[17].ovf);
            end
            if (got_q[3].val != exp_q[3].val) begin
                errors++; $display("FAIL sat_4th: got %0d, required %0d", got_q[3].val, exp_q[3].val);
            end
        end
        clear_acc();
        #1;
        checks++;
        if (bus.ovf !== 1'b0) begin errors++; $display("FAIL sat_clear_ovf: got %0b, required 0", bus.ovf); end
        exp_q.delete();
        add_op(1, 1, 0, MODE_ACC);
        run_ops(1000, 0, 0);
        checks++;
        if (got_q.size() != 1 || got_q[0].val != 1 || got_q[0].ovf !== 1'b0) begin
            errors++; $display("FAIL sat_after_clear: got %0d results first %0d, required 1 result value 1", got_q.size(), (got_q.size() > 0) ? got_q[0].val : -1);
        end
    endtask

    task automatic test_random_mixed();
        int s_at, s_len;
        clear_acc();
        exp_q.delete();
        for (int i = 0; i < 24; i++) begin
            add_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), logic'($urandom_range(0, 1)));
        end
        s_at  = int'($urandom_range(4, 10));
        s_len = int'($urandom_range(1, 5));
        run_ops(s_at, s_len, 0);
        checks += 2;
        if (got_q.size() != 24) begin errors++; $display("FAIL rand_count: got %0d, required 24", got_q.size()); end
        if (hold_bad != 0 || stall_bad != 0) begin
            errors++; $display("FAIL rand_stall: hold_bad=%0d stall_bad=%0d, required 0 0", hold_bad, stall_bad);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].val != exp_q[i].val || got_q[i].ovf !== exp_q[i].ovf) begin
                errors++; $display("FAIL rand_value[%0d]: got %0d ovf %0b, required %0d ovf %0b", i, got_q[i].val, got_q[i].ovf, exp_q[i].val, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_reset_inflight();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.a = 8'd5; bus.b = 8'd5; bus.c = 8'd5; bus.mode = MODE_ACC;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL inflight_first_out: got %0b, required 1", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL inflight_reset_valid: got %0b, required 0", bus.out_valid); end
        if (bus.out !== '0) begin errors++; $display("FAIL inflight_reset_out: got %0d, required 0", bus.out); end
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 0; m_ovf = 1'b0;
        exp_q.delete();
        run_ops(1000, 0, 8);
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL inflight_no_output: got %0d results, required 0", got_q.size()); end
        add_op(1, 1, 0, MODE_ACC);
        run_ops(1000, 0, 0);
        checks++;
        if (got_q.size() != 1 || got_q[0].val != 1) begin
            errors++; $display("FAIL inflight_acc_zero: got %0d results first %0d, required 1 result value 1", got_q.size(), (got_q.size() > 0) ? got_q[0].val : -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_max_muladd();
        test_stream();
        test_stall();
        test_accumulate();
        test_saturation();
        test_random_mixed();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mul_add_pipe
`default_nettype wire

// File: doc/mul_add_pipe.md
Name: mul_add_pipe

Overview:
- Parametrised pipelined unsigned multiply-add unit. It supersedes the fixed 8-bit a*b+c multiplier.
- Adds valid/ready flow control, configurable operand width and pipeline depth, and a saturating accumulate mode.
- Sits between operand producers and any consumer of arithmetic results in the seminar datapath.

Parameters:
- W, 8, operand width of a, b and c (unsigned).
- STAGES, 3, latency in cycles from input acceptance to out_valid; legal range 1..4.
- ACC_W, 2*W+4, result/accumulator width; must be >= 2*W+1 (elaboration-time check fails otherwise).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set present
- in_ready  out  1  unit can accept operands this cycle
- a  in  W  multiplicand
- b  in  W  multiplier
- c  in  W  addend
- mode  in  1  0 = multiply-add, 1 = accumulate; travels with the operand set
- clr_acc  in  1  synchronous clear of accumulator and ovf
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out  out  ACC_W  result
- ovf  out  1  sticky accumulator saturation flag

Behaviour:
- Reset (async assert, sync deassert): every stage valid bit = 0, out = 0, out_valid = 0, accumulator = 0, ovf = 0. In-flight operations are discarded; nothing is emitted after release until new inputs arrive.
- Acceptance: a transfer occurs when in_valid && in_ready at the rising clk edge. Transfer on the output side occurs when out_valid && out_ready.
- Global stall: stall = out_valid && !out_ready. When stalled, every pipeline register holds and in_ready = 0. Otherwise in_ready = 1, including bubbles; no skid buffer.
- Latency: exactly STAGES cycles with no stall. Throughput: 1 result per cycle. Order is preserved.
- Pipeline structure:
  - Stage 1 registers a, b, c, mode.
  - The product a*b (2W bits) plus zero-extended c is formed and delayed through the remaining stages.
  - The final stage is the output register plus accumulator update.
  - STAGES = 1: purely combinational arithmetic into the output register.
- mode 0: out = a*b + c, zero-extended to ACC_W. Cannot overflow (max (2^W-1)^2 + 2^W-1 < 2^(2W)). Accumulator is untouched.
- mode 1:
  - At the edge where the operation enters the output register: acc_next = acc + a*b + c.
  - If the true sum exceeds 2^ACC_W-1, acc saturates to all-ones and ovf is set.
  - out = acc_next.
  - Once saturated, further adds keep all-ones.
- ovf is sticky and changes only via clr_acc or reset.
- clr_acc:
  - Clears acc and ovf at the next edge, independent of stall.
  - If asserted on the same edge a mode-1 operation enters the output register, the clear applies first: acc_next = a*b + c, and ovf is recomputed from that sum.
  - No effect on mode-0 results or pipeline contents.
- out and out_valid are registered. out holds its value while stalled. When no result is present, out keeps its last value.
- Mixed mode streams are legal back-to-back. mode-0 results do not disturb acc.

Decomposition:
- Shared package: MODE_MULADD = 1'b0, MODE_ACC = 1'b1, and the function computing the default ACC_W from W.
- Sub-module pipe_stage: an enable-gated register carrying {valid, mode, sum}, reset to zero, instantiated STAGES-1 times via generate.
- The final output/accumulator stage stays in the top module.

Test Plan (W=8, STAGES=3, ACC_W=20, out_ready=1 unless stated):
- mode 0, a=3 b=4 c=5, single pulse -> out=17, out_valid high for exactly one cycle, 3 cycles after acceptance.
- mode 0, a=b=c=255 -> out=65280, ovf stays 0.
- Stream of 10 ops, a=i, b=i+1, c=i for i=1..10 -> 10 consecutive out_valid cycles, out = i*(i+1)+i in order, in_ready constantly 1.
- Stream with out_ready=0 for 4 cycles mid-stream -> in_ready=0 during stall, out held stable, no result lost or duplicated; totals match the no-stall run.
- clr_acc, then mode 1 a=10 b=10 c=0 three times -> outs 100, 200, 300.
- Saturation: mode 1 a=b=c=255 seventeen times:
  - 16th -> out=1044480, ovf=0.
  - 17th -> out=1048575, ovf=1.
  - clr_acc -> ovf=0.
  - Next a=1 b=1 c=0 -> out=1.
- Extra check: rst_n pulsed low while 2 ops are in flight -> out_valid=0 immediately; no outputs after release; acc=0.
